fwd_hazard_unit: RTL and testbench

- Producer side of the 3-input operand select muxes in the pipelined CPU datapath.
- Holds its own copy of the destination-register tags for the ID/EX, EX/MEM and MEM/WB stages.
- Generates the 2-bit forwarding selects for both EX-stage ALU operands.
- Detects load-use hazards, drives the pipeline stall and bubble control, and counts stall cycles for performance debug.

---
 rtl/fwd_hazard_unit.sv | 123 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for the EX stage of the pipelined CPU.
// Tracks destination tags for ID/EX, EX/MEM and MEM/WB, and counts stall cycles.
module fwd_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_dst_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    logic [REG_W-1:0] ex_dst_q, ex_dst_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memread_q, ex_memread_d;
    logic [REG_W-1:0] mem_dst_q, mem_dst_d;
    logic             mem_regwrite_q, mem_regwrite_d;
    logic [REG_W-1:0] wb_dst_q, wb_dst_d;
    logic             wb_regwrite_q, wb_regwrite_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             bubble;
    logic [REG_W-1:0] ex_src [2];
    logic [1:0]       fwd_sel [2];

    assign ex_src[0] = ex_rs_q;
    assign ex_src[1] = ex_rt_q;

    // EX/MEM wins over MEM/WB because it holds the younger result.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (mem_regwrite_q && (mem_dst_q != REG_ZERO) && (mem_dst_q == ex_src[gi])) begin
                    fwd_sel[gi] = 2'b10;
                end else if (wb_regwrite_q && (wb_dst_q != REG_ZERO) && (wb_dst_q == ex_src[gi])) begin
                    fwd_sel[gi] = 2'b01;
                end
            end
        end
    endgenerate

    assign fwd_a_o = fwd_sel[0];
    assign fwd_b_o = fwd_sel[1];

    always_comb begin
        stall_o = id_valid_i && ex_memread_q && (ex_dst_q != REG_ZERO) &&
                  ((ex_dst_q == id_rs_i) || (ex_dst_q == id_rt_i));
    end

    assign bubble = stall_o || flush_i || !id_valid_i;

    always_comb begin
        wb_dst_d       = mem_dst_q;
        wb_regwrite_d  = mem_regwrite_q;
        mem_dst_d      = ex_dst_q;
        mem_regwrite_d = ex_regwrite_q;
        ex_rs_d        = id_rs_i;
        ex_rt_d        = id_rt_i;
        ex_dst_d       = id_dst_i;
        ex_regwrite_d  = id_regwrite_i;
        ex_memread_d   = id_memread_i;
        if (bubble) begin
            ex_rs_d       = '0;
            ex_rt_d       = '0;
            ex_dst_d      = '0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
        end
    end

    // Saturating count so a long debug run never reports a misleadingly small value.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dst_q       <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_dst_q      <= '0;
            mem_regwrite_q <= 1'b0;
            wb_dst_q       <= '0;
            wb_regwrite_q  <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dst_q       <= ex_dst_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_dst_q      <= mem_dst_d;
            mem_regwrite_q <= mem_regwrite_d;
            wb_dst_q       <= wb_dst_d;
            wb_regwrite_q  <= wb_regwrite_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// instruction-level pipeline model that tracks which instruction sits in each stage.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_rw, id_mr;
    logic        flush;
    logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
    logic        stall, stall_s;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_dst_i(id_dst), .id_regwrite_i(id_rw), .id_memread_i(id_mr), .flush_i(flush),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .stall_cnt_o(cnt)
    );

    fwd_hazard_unit #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_dst_i(id_dst), .id_regwrite_i(id_rw), .id_memread_i(id_mr), .flush_i(flush),
        .fwd_a_o(fwd_a_s), .fwd_b_o(fwd_b_s), .stall_o(stall_s), .stall_cnt_o(cnt_s)
    );

    // Instruction record occupying a pipeline stage; a bubble is the all-zero record.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
    } instr_t;

    instr_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int     m_cnt;

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].rw && pipe[s].dst != 5'd0 && pipe[s].dst == src)
                return (s == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        return id_valid && pipe[0].mr && pipe[0].dst != 5'd0 &&
               (pipe[0].dst == id_rs || pipe[0].dst == id_rt);
    endfunction

    function automatic int m_cnt16();
        return (m_cnt > 65535) ? 65535 : m_cnt;
    endfunction

    function automatic int m_cnt2();
        return (m_cnt > 3) ? 3 : m_cnt;
    endfunction

    // One clock edge for DUT and model; returns at the following falling edge.
    task automatic tick();
        logic   s;
        instr_t nxt;
        s   = m_stall();
        nxt = '{id_rs, id_rt, id_dst, id_rw, id_mr};
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            m_cnt = 0;
        end else begin
            if (s) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (s || flush || !id_valid) ? '0 : nxt;
        end
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst; id_rw = rw; id_mr = mr;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0;
        nop();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'(($urandom) & 1);
        for (int c = 0; c < 2; c++) begin
            set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_bad++;
            $display("FAIL reset_fwd: got a=%b b=%b want 00 00", fwd_a, fwd_b); end
        n_cmp++; if (stall !== 1'b0 || cnt !== 16'd0) begin n_bad++;
            $display("FAIL reset_stall_cnt: got stall=%b cnt=%0d want 0 0", stall, cnt); end
        rst = 1'b0; flush = 1'b0;
        nop();
        n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0 || cnt !== 16'd0) begin n_bad++;
            $display("FAIL reset_post: got a=%b b=%b stall=%b cnt=%0d want all 0", fwd_a, fwd_b, stall, cnt); end
        $display("test_reset done");
    endtask

    task automatic test_ex_mem_fwd();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();   // add $3
        set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0); tick();   // sub $6,$3,$4
        nop();
        n_cmp++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin n_bad++;
            $display("FAIL ex_mem_fwd: got a=%b b=%b want 10 00", fwd_a, fwd_b); end
        $display("test_ex_mem_fwd: a=%b b=%b", fwd_a, fwd_b);
    endtask

    task automatic test_mem_wb_fwd();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
        nop(); tick();
        set_id(1'b1, 5'd5, 5'd7, 5'd10, 1'b1, 1'b0); tick();
        nop();
        n_cmp++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin n_bad++;
            $display("FAIL mem_wb_fwd: got a=%b b=%b want 01 00", fwd_a, fwd_b); end
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd11, 1'b1, 1'b0); tick();
        nop();
        n_cmp++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin n_bad++;
            $display("FAIL fwd_priority: got a=%b b=%b want 10 10", fwd_a, fwd_b); end
        $display("test_mem_wb_fwd done");
    endtask

    task automatic test_reg_zero();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0); tick();
        set_id(1'b1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0); tick();
        nop();
        n_cmp++; if (fwd_a !== 2'b00) begin n_bad++;
            $display("FAIL zero_fwd: got a=%b want 00", fwd_a); end
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1); tick();   // lw $0
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL zero_stall: got stall=%b want 0", stall); end
        tick(); nop();
        $display("test_reg_zero done");
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1); tick();   // lw $8
        set_id(1'b1, 5'd2, 5'd8, 5'd9, 1'b1, 1'b0);           // consumer of $8
        n_cmp++; if (stall !== 1'b1 || cnt !== 16'd0) begin n_bad++;
            $display("FAIL load_use_stall: got stall=%b cnt=%0d want 1 0", stall, cnt); end
        tick();
        n_cmp++; if (stall !== 1'b0 || cnt !== 16'd1) begin n_bad++;
            $display("FAIL load_use_release: got stall=%b cnt=%0d want 0 1", stall, cnt); end
        tick();
        nop();
        n_cmp++; if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin n_bad++;
            $display("FAIL load_use_fwd: got a=%b b=%b want 00 01", fwd_a, fwd_b); end
        $display("test_load_use done cnt=%0d", cnt);
    endtask

    task automatic test_flush();
        do_reset();
        nop(); tick(); tick();
        flush = 1'b1;
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0); tick();
        flush = 1'b0;
        set_id(1'b1, 5'd9, 5'd9, 5'd12, 1'b1, 1'b0); tick();
        nop(); tick();
        n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_bad++;
            $display("FAIL flush_fwd: got a=%b b=%b want 00 00", fwd_a, fwd_b); end
        $display("test_flush done");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_id(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1); tick();
            set_id(1'b1, 5'd8, 5'd3, 5'd9, 1'b1, 1'b0);
            n_cmp++; if (stall_s !== 1'b1) begin n_bad++;
                $display("FAIL sat_stall%0d: got %b want 1", k, stall_s); end
            tick(); tick();
            nop();
        end
        n_cmp++; if (cnt_s !== 2'd3 || cnt !== 16'd4) begin n_bad++;
            $display("FAIL saturation: got cnt2=%0d cnt16=%0d want 3 4", cnt_s, cnt); end
        $display("test_saturation cnt2=%0d cnt16=%0d", cnt_s, cnt);
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1); tick();
        set_id(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0);
        flush = 1'b1; rst = 1'b1;
        tick();
        #1;
        n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0 || cnt !== 16'd0 || cnt_s !== 2'd0) begin n_bad++;
            $display("FAIL reset_mid: got a=%b b=%b stall=%b cnt=%0d want all 0", fwd_a, fwd_b, stall, cnt); end
        rst = 1'b0; flush = 1'b0;
        nop();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int bad0;
        bad0 = n_bad;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_id(($urandom_range(0, 5) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 2) == 0));
            n_cmp++; if (fwd_a !== m_fwd(pipe[0].rs) || fwd_b !== m_fwd(pipe[0].rt)) begin n_bad++;
                $display("FAIL rand_fwd c=%0d: got a=%b b=%b want %b %b", c, fwd_a, fwd_b,
                         m_fwd(pipe[0].rs), m_fwd(pipe[0].rt)); end
            n_cmp++; if (stall !== m_stall() || stall_s !== m_stall()) begin n_bad++;
                $display("FAIL rand_stall c=%0d: got %b/%b want %b", c, stall, stall_s, m_stall()); end
            n_cmp++; if (int'(cnt) != m_cnt16() || int'(cnt_s) != m_cnt2()) begin n_bad++;
                $display("FAIL rand_cnt c=%0d: got %0d/%0d want %0d/%0d", c, cnt, cnt_s, m_cnt16(), m_cnt2()); end
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        $display("test_random: 400 cycles, %0d new mismatches", n_bad - bad0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_cnt = 0;
        rst = 1'b1; flush = 1'b0;
        nop();
        @(negedge clk);
        test_reset();
        test_ex_mem_fwd();
        test_mem_wb_fwd();
        test_reg_zero();
        test_load_use();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
